pim_out_encoder: RTL and testbench



---
 rtl/pim_enc_pkg.sv | 24 ++
 rtl/pim_therm_decode.sv | 28 ++
 rtl/pim_out_encoder.sv | 147 ++++++++++++++
 tb/tb_pim_out_encoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pim_enc_pkg.sv
// Shared mode codes, frame FSM states and the row-by-row lookup table
// for the eFlash output encoder.
package pim_enc_pkg;

    localparam logic [2:0] MODE_PAR = 3'b101;
    localparam logic [2:0] MODE_RBR = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        EMIT
    } pim_enc_state_e;

    localparam logic [3:0] RBR_LUT [9] = '{4'd9, 4'd9, 4'd6, 4'd6, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};

    // Non-8-bit thermometers have no characterised table; fall back to TW-count.
    function automatic int unsigned rbr_map(input int unsigned tw, input int unsigned cnt);
        if (tw == 8) begin
            return 32'(RBR_LUT[cnt[3:0]]);
        end
        return tw - cnt;
    endfunction

endpackage

// File: rtl/pim_therm_decode.sv
// Thermometer decoder: counts MSB-first leading ones; any code that is not
// ones-then-zeros is flagged invalid and reported as count 0.
module pim_therm_decode #(
    parameter int unsigned TW = 8,
    localparam int unsigned CW = $clog2(TW + 1)
) (
    input  logic [TW-1:0] data_i,
    output logic [CW-1:0] count_o,
    output logic          valid_o
);

    logic [CW-1:0] ones;

    always_comb begin
        ones    = '0;
        valid_o = 1'b1;
        for (int unsigned i = 0; i < TW; i++) begin
            ones = ones + CW'(data_i[i]);
        end
        for (int unsigned i = 0; i + 1 < TW; i++) begin
            if (data_i[i] && !data_i[i+1]) begin
                valid_o = 1'b0;
            end
        end
        count_o = valid_o ? ones : '0;
    end

endmodule

// File: rtl/pim_out_encoder.sv
// eFlash output slot buffer and encoder (row-by-row LUT / parallel radix-TW).
// Optional error-frame counter port err_cnt_o under PIM_ENC_ERR_CNT_EN.
module pim_out_encoder
    import pim_enc_pkg::*;
#(
    parameter int unsigned TW    = 8,
    parameter int unsigned SLOTS = 2,
    parameter int unsigned OUT_W = 7
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [2:0]       pim_mode_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [TW-1:0]    in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic             out_err_o
`ifdef PIM_ENC_ERR_CNT_EN
    ,
    output logic [15:0]      err_cnt_o
`endif
);

    localparam int unsigned CNT_W  = $clog2(TW + 1);
    localparam int unsigned ACC_W  = $clog2((TW + 1) ** SLOTS);
    localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned CMP_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam logic [CMP_W-1:0] OUT_MAX = CMP_W'({OUT_W{1'b1}});

    pim_enc_state_e    state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              err_q, err_d;
    logic [OUT_W-1:0]  data_q, data_d;
    logic              oerr_q, oerr_d;

    logic [CNT_W-1:0]  cnt;
    logic              cnt_valid;
    logic              beat_fire;
    logic [ACC_W-1:0]  acc_next;
    logic              par_sat;
    logic [OUT_W-1:0]  par_data;
    logic [OUT_W-1:0]  rbr_data;

    pim_therm_decode #(.TW(TW)) u_decode (
        .data_i  (in_data_i),
        .count_o (cnt),
        .valid_o (cnt_valid)
    );

    assign in_ready_o  = (state_q != EMIT);
    assign out_valid_o = (state_q == EMIT);
    assign out_data_o  = data_q;
    assign out_err_o   = oerr_q;
    assign beat_fire   = in_valid_i && in_ready_o;

    always_comb begin
        acc_next = (acc_q * ACC_W'(TW)) + ACC_W'(cnt);
        par_sat  = CMP_W'(acc_next) > OUT_MAX;
        par_data = par_sat ? '1 : OUT_W'(acc_next);
        rbr_data = OUT_W'(rbr_map(TW, 32'(cnt)));
    end

    // FILL is only reachable in parallel mode, so the mode seen on the first
    // beat is the only one that matters; later pim_mode_i values are ignored.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        acc_d   = acc_q;
        err_d   = err_q;
        data_d  = data_q;
        oerr_d  = oerr_q;
        unique case (state_q)
            IDLE, FILL: begin
                if (flush_i) begin
                    state_d = IDLE;
                    slot_d  = '0;
                    acc_d   = '0;
                    err_d   = 1'b0;
                end else if (beat_fire) begin
                    if (state_q == IDLE && pim_mode_i == MODE_RBR) begin
                        state_d = EMIT;
                        data_d  = rbr_data;
                        oerr_d  = ~cnt_valid;
                    end else if (state_q == FILL || pim_mode_i == MODE_PAR) begin
                        acc_d = acc_next;
                        if ((state_q == IDLE && SLOTS == 1) ||
                            (state_q == FILL && slot_q == SLOT_W'(SLOTS - 1))) begin
                            state_d = EMIT;
                            data_d  = par_data;
                            oerr_d  = err_q | ~cnt_valid | par_sat;
                        end else begin
                            state_d = FILL;
                            slot_d  = slot_q + SLOT_W'(1);
                            err_d   = err_q | ~cnt_valid;
                        end
                    end
                end
            end
            EMIT: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                    slot_d  = '0;
                    acc_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            slot_q  <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            data_q  <= data_d;
            oerr_q  <= oerr_d;
        end
    end

`ifdef PIM_ENC_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else if (state_q == EMIT && out_ready_i && oerr_q && err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_pim_out_encoder.sv
// Randomised bench for pim_out_encoder: two instances (OUT_W=7 and OUT_W=6)
// share stimulus and are checked against a frame-level reference model.
module tb_pim_out_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] pim_mode;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, out_err_a;
    logic [6:0] out_data_a;
    logic       in_ready_b, out_valid_b, out_err_b;
    logic [5:0] out_data_b;
`ifdef PIM_ENC_ERR_CNT_EN
    logic [15:0] err_cnt_a, err_cnt_b;
`endif

    int checks = 0;
    int errors = 0;
    int exp_cnt_a = 0;
    int exp_cnt_b = 0;
    logic [7:0] beats[$];

    always #5 clk = ~clk;

    pim_out_encoder #(.TW(8), .SLOTS(2), .OUT_W(7)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .pim_mode_i(pim_mode), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready_a), .in_data_i(in_data),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready), .out_data_o(out_data_a),
        .out_err_o(out_err_a)
`ifdef PIM_ENC_ERR_CNT_EN
        , .err_cnt_o(err_cnt_a)
`endif
    );

    pim_out_encoder #(.TW(8), .SLOTS(2), .OUT_W(6)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .pim_mode_i(pim_mode), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready_b), .in_data_i(in_data),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready), .out_data_o(out_data_b),
        .out_err_o(out_err_b)
`ifdef PIM_ENC_ERR_CNT_EN
        , .err_cnt_o(err_cnt_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count of a legal thermometer code, or -1 when the code is not one.
    function automatic int model_count(input logic [7:0] d);
        logic [7:0] ones;
        logic [7:0] pat;
        ones = 8'hFF;
        for (int k = 0; k <= 8; k++) begin
            pat = ones << (8 - k);
            if (d == pat) return k;
        end
        return -1;
    endfunction

    task automatic model(input bit rbr, input int outw, output int data, output bit err);
        int lut[9] = '{9, 9, 6, 6, 4, 3, 2, 1, 0};
        int c;
        int acc;
        int maxv;
        err = 1'b0;
        if (rbr) begin
            c = model_count(beats[0]);
            if (c < 0) begin c = 0; err = 1'b1; end
            data = lut[c];
        end else begin
            acc = 0;
            foreach (beats[i]) begin
                c = model_count(beats[i]);
                if (c < 0) begin c = 0; err = 1'b1; end
                acc = acc * 8 + c;
            end
            maxv = (1 << outw) - 1;
            if (acc > maxv) begin acc = maxv; err = 1'b1; end
            data = acc;
        end
    endtask

    function automatic logic [7:0] gen_beat();
        logic [7:0] ones;
        int k;
        ones = 8'hFF;
        if ($urandom_range(0, 3) == 0) return 8'($urandom);
        k = $urandom_range(0, 8);
        return ones << (8 - k);
    endfunction

    task automatic send(input logic [2:0] mode, input logic [7:0] d);
        check("send_ready", in_ready_a, 1);
        pim_mode = mode;
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic finish_frame(input string tag, input bit rbr, input int hold);
        int ea, eb;
        bit fa, fb;
        model(rbr, 7, ea, fa);
        model(rbr, 6, eb, fb);
        check({tag, "_valid"}, out_valid_a, 1);
        check({tag, "_valid_b"}, out_valid_b, 1);
        check({tag, "_data"}, out_data_a, ea);
        check({tag, "_err"}, out_err_a, fa);
        check({tag, "_data_b"}, out_data_b, eb);
        check({tag, "_err_b"}, out_err_b, fb);
        check({tag, "_busy"}, in_ready_a, 0);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            flush    = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            step();
            check({tag, "_hold_valid"}, out_valid_a, 1);
            check({tag, "_hold_data"}, out_data_a, ea);
            check({tag, "_hold_err_b"}, out_err_b, fb);
            check({tag, "_hold_busy"}, in_ready_a, 0);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        if (fa && exp_cnt_a < 65535) exp_cnt_a++;
        if (fb && exp_cnt_b < 65535) exp_cnt_b++;
        check({tag, "_done_valid"}, out_valid_a, 0);
        check({tag, "_done_ready"}, in_ready_a, 1);
`ifdef PIM_ENC_ERR_CNT_EN
        check({tag, "_errcnt"}, err_cnt_a, exp_cnt_a);
        check({tag, "_errcnt_b"}, err_cnt_b, exp_cnt_b);
`endif
    endtask

    task automatic run_frame(input string tag, input bit rbr, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [2:0] m1,
                             input int gap, input int hold);
        beats.delete();
        beats.push_back(b0);
        send(rbr ? 3'b110 : 3'b101, b0);
        if (!rbr) begin
            for (int i = 0; i < gap; i++) begin
                pim_mode = 3'($urandom);
                step();
                check({tag, "_gap_valid"}, out_valid_a, 0);
            end
            beats.push_back(b1);
            send(m1, b1);
        end
        finish_frame(tag, rbr, hold);
    endtask

    initial begin
        rst_n     = 1'b0;
        pim_mode  = 3'b000;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        step();
        step();
        check("rst_valid", out_valid_a, 0);
        check("rst_data", out_data_a, 0);
        check("rst_err", out_err_a, 0);
        check("rst_ready", in_ready_a, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_frame("par_35", 1'b0, 8'b11110000, 8'b11100000, 3'b101, 0, 0);
        check("par_35_const", out_data_a, 35);
        run_frame("rbr_3", 1'b1, 8'b11111000, 8'h00, 3'b110, 0, 0);
        run_frame("rbr_9", 1'b1, 8'b00000000, 8'h00, 3'b110, 0, 1);
        run_frame("rbr_bad", 1'b1, 8'b10100000, 8'h00, 3'b110, 0, 0);
        run_frame("par_hold", 1'b0, 8'b11000000, 8'b10000000, 3'b101, 1, 5);
        run_frame("par_sat", 1'b0, 8'hFF, 8'hFF, 3'b101, 0, 2);
        run_frame("par_modechg", 1'b0, 8'b10000000, 8'b11000000, 3'b110, 0, 0);

        // Partial frame aborted by flush with a beat presented in the same cycle.
        send(3'b101, 8'b11110000);
        pim_mode = 3'b101;
        in_data  = 8'hFF;
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", out_valid_a, 0);
        check("flush_ready", in_ready_a, 1);
        run_frame("flush_64", 1'b0, 8'hFF, 8'h00, 3'b101, 0, 0);

        send(3'b000, 8'hFF);
        check("illegal_valid", out_valid_a, 0);
        send(3'b111, 8'hE0);
        step();
        check("illegal_valid2", out_valid_a, 0);
        check("illegal_ready", in_ready_a, 1);

        for (int n = 0; n < 40; n++) begin
            int sel;
            sel = $urandom_range(0, 4);
            if (sel == 4) begin
                send(3'($urandom_range(0, 4)), gen_beat());
                check("rand_illegal_valid", out_valid_a, 0);
            end else begin
                run_frame("rand", sel == 0, gen_beat(), gen_beat(), 3'($urandom),
                          $urandom_range(0, 2), $urandom_range(0, 3));
            end
        end

        // Async reset while a result is pending.
        send(3'b101, 8'hFF);
        send(3'b101, 8'h5A);
        step();
        check("prereset_valid", out_valid_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt_a = 0;
        exp_cnt_b = 0;
        check("async_rst_valid", out_valid_a, 0);
        check("async_rst_ready", in_ready_a, 1);
        check("async_rst_data", out_data_a, 0);
        check("async_rst_err", out_err_b, 0);
`ifdef PIM_ENC_ERR_CNT_EN
        check("async_rst_errcnt", err_cnt_a, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_frame("post_rst", 1'b0, 8'b11100000, 8'b11111111, 3'b101, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
